cpu_control_unit: RTL and testbench
===================================

# cpu_control_unit

Sequencing controller for the 4-bit CPU: owns the program counter, drives the address into the combinational instruction ROM, latches the returned opcode/operand into an instruction register, and issues one-cycle control strobes to the accumulator/ALU datapath. It sits between the ROM (address out; opcode and operand in) and the datapath (strobes out; zero flag in). Each instruction takes a fixed three-cycle FETCH/DECODE/EXECUTE sequence.

## Interface
- No parameters. Widths are fixed by the ISA in `cpu_pkg`: 4-bit address, 4-bit opcode, 4-bit operand.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- `rom_addr`  out  4  current PC, fed to the ROM address input.
- `rom_opcode`  in  4  ROM opcode for `rom_addr` (combinational, valid the same cycle).
- `rom_operand`  in  4  ROM operand for `rom_addr`.
- `zero_flag`  in  1  datapath accumulator == 0.
- `ctl_acc_we`  out  1  accumulator write strobe.
- `ctl_alu_op`  out  2  00 PASS, 01 ADD, 10 SUB.
- `ctl_imm`  out  4  immediate operand for the datapath.
- `ctl_out_we`  out  1  output-port write strobe.
- `halted`  out  1  1 while in HALT.
- `state`  out  2  debug: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE. HALT reads as 0 with `halted`=1.

## Operation
- ISA:
  - 0x0 NOP.
  - 0x1 LDI: acc <= imm.
  - 0x2 ADDI.
  - 0x3 SUBI.
  - 0x4 JMP: pc <= imm.
  - 0x5 JZ: pc <= imm if `zero_flag`.
  - 0x6 OUT.
  - 0xF HLT.
  - 0x7–0xE are treated as NOP.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, HALT.
  - IDLE -> FETCH when `run`=1.
  - FETCH -> DECODE. IR <= {`rom_opcode`, `rom_operand`}; pc <= pc+1, modulo 16 (0xF wraps to 0x0).
  - DECODE -> EXECUTE. The decoder registers the strobe set from IR.
  - EXECUTE -> HALT if the opcode is HLT. Otherwise -> FETCH if `run`=1, else -> IDLE.
  - HALT is left only by `rst`. `run` is ignored in HALT.
- Strobes are high only during the EXECUTE cycle:
  - LDI: `ctl_acc_we`=1, `ctl_alu_op`=PASS.
  - ADDI / SUBI: `ctl_acc_we`=1, `ctl_alu_op`=ADD / SUB.
  - OUT: `ctl_out_we`=1.
  - `ctl_imm` = IR operand in DECODE and EXECUTE, 0 otherwise.
- Jumps:
  - JMP overwrites pc at the end of EXECUTE.
  - JZ samples `zero_flag` in the EXECUTE cycle. If it is 0, pc keeps its already-incremented value.
- `run` is sampled only in IDLE and EXECUTE, so an instruction in flight always completes.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE, pc = 0, IR = 0.
  - All strobes = 0, `ctl_imm` = 0, `halted` = 0.
- `rom_addr` is the registered pc. The ROM returns data combinationally, so it is captured at the end of the same FETCH cycle.
- Instruction latency is 3 cycles, FETCH to the end of EXECUTE. Throughput is 1 instruction per 3 cycles.
- With `run` held high from reset release: first FETCH at cycle 1, first EXECUTE strobe at cycle 3.
- A jump target appears on `rom_addr` in the cycle after EXECUTE, which is the next FETCH.
- Reset mid-instruction aborts it. No strobe is issued, and pc returns to 0.
- Wrap: a non-jump instruction at 0xF continues fetching from 0x0.

## Structure
- `cpu_pkg` holds:
  - `opcode_t` enum (NOP, LDI, ADDI, SUBI, JMP, JZ, OUT, HLT=4'hF).
  - `alu_op_t` (PASS, ADD, SUB).
  - `ctl_state_t` FSM enum.
  - Width constants `ADDR_W`=4, `DATA_W`=4.
- One sub-module, `cpu_decoder`: purely combinational, opcode -> {acc_we, alu_op, out_we, is_jmp, is_jz, is_hlt}. It is instantiated in the control unit and reusable by the bench's reference model.
- The control unit keeps the FSM, pc, IR and the registered strobe stage.

## Test plan
- **Reset / idle:** assert `rst` mid-run (pc=0x5, state EXECUTE) -> immediately pc=0, all strobes 0, state=IDLE. With `run`=0 after release, `rom_addr` stays 0x0 indefinitely.
- **Straight-line:** ROM[0]=LDI 3, ROM[1]=ADDI 2, ROM[2]=OUT, ROM[3]=HLT, `run`=1. Required response:
  - `ctl_acc_we` pulses at cycles 3 and 6, with `ctl_imm` 3 (PASS) then 2 (ADD).
  - `ctl_out_we` pulses at cycle 9.
  - `halted`=1 from cycle 13, and pc stays 0x4.
- **Jumps:** ROM[0]=JMP 0xA, ROM[0xA]=JZ 0x2.
  - `rom_addr` reads 0xA in the FETCH after the first EXECUTE.
  - With `zero_flag`=1 the next fetch is 0x2. With `zero_flag`=0 it is 0xB.
- **Wrap:** ROM filled with NOP, `run`=1 -> `rom_addr` steps 0xE, 0xF, 0x0 every 3 cycles, with no strobes.
- **Run gating:** drop `run` during a DECODE -> that instruction's EXECUTE strobe still fires, then state=IDLE with pc pointing at the next instruction. Re-raising `run` resumes from that pc.
- **HALT stickiness:** after HLT, toggling `run` -> no state change. Only `rst` clears `halted`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the 4-bit CPU: opcode, ALU op and control FSM
// encodings, plus the instruction-register and decoded-strobe bundles.
// Latency: n/a (types only). Backpressure: n/a.
package cpu_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADDI = 4'h2,
    OP_SUBI = 4'h3,
    OP_JMP  = 4'h4,
    OP_JZ   = 4'h5,
    OP_OUT  = 4'h6,
    OP_HLT  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10
  } alu_op_t;

  // Low two bits of the running states match the debug state encoding.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } ctl_state_t;

  // Opcode kept as raw bits so 0x7-0xE survive into the decoder as NOPs.
  typedef struct packed {
    logic [3:0]        opcode;
    logic [DATA_W-1:0] operand;
  } ir_t;

  typedef struct packed {
    logic    acc_we;
    alu_op_t alu_op;
    logic    out_we;
    logic    is_jmp;
    logic    is_jz;
    logic    is_hlt;
  } dec_t;

endpackage

// File: rtl/cpu_control_unit_if.sv
// Bundle between the control unit, the instruction ROM and the datapath.
// master = control unit side (drives address/strobes), slave = ROM/datapath/bench side.
// Latency: n/a (wires only). Backpressure: none, run is a level enable.
interface cpu_control_unit_if;
  import cpu_pkg::*;

  logic              run;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_opcode;
  logic [DATA_W-1:0] rom_operand;
  logic              zero_flag;
  logic              ctl_acc_we;
  logic [1:0]        ctl_alu_op;
  logic [DATA_W-1:0] ctl_imm;
  logic              ctl_out_we;
  logic              halted;
  logic [1:0]        state;

  modport master (
    input  run, rom_opcode, rom_operand, zero_flag,
    output rom_addr, ctl_acc_we, ctl_alu_op, ctl_imm, ctl_out_we, halted, state
  );

  modport slave (
    output run, rom_opcode, rom_operand, zero_flag,
    input  rom_addr, ctl_acc_we, ctl_alu_op, ctl_imm, ctl_out_we, halted, state
  );

endinterface

// File: rtl/cpu_decoder.sv
// Combinational opcode decoder: opcode -> {acc_we, alu_op, out_we, is_jmp, is_jz, is_hlt}.
// Latency: 0 cycles. Backpressure: none.
// Ports: opcode (in, 4), dec (out, dec_t). Unassigned opcodes decode as NOP.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_LDI:  begin dec.acc_we = 1'b1; dec.alu_op = ALU_PASS; end
      OP_ADDI: begin dec.acc_we = 1'b1; dec.alu_op = ALU_ADD;  end
      OP_SUBI: begin dec.acc_we = 1'b1; dec.alu_op = ALU_SUB;  end
      OP_JMP:  dec.is_jmp = 1'b1;
      OP_JZ:   dec.is_jz  = 1'b1;
      OP_OUT:  dec.out_we = 1'b1;
      OP_HLT:  dec.is_hlt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Sequencing controller: PC, instruction register, FETCH/DECODE/EXECUTE FSM and
// a registered strobe stage that is live only in EXECUTE.
// Latency: 3 cycles per instruction. Backpressure: run=0 stops at the next instruction boundary.
// Ports: clk, rst (async, active-high), bus (cpu_control_unit_if.master).
module cpu_control_unit
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  cpu_control_unit_if.master    bus
);

  ctl_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  ir_t               ir_q, ir_d;
  dec_t              dec_q, dec_d;
  dec_t              dec_now;

  cpu_decoder u_dec (
    .opcode (ir_q.opcode),
    .dec    (dec_now)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    // Strobe register is loaded only at the end of DECODE, so it is
    // non-zero for exactly the following EXECUTE cycle.
    dec_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = '{opcode: bus.rom_opcode, operand: bus.rom_operand};
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        dec_d   = dec_now;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        // Taken jump overrides the already-incremented pc.
        if (dec_q.is_jmp || (dec_q.is_jz && bus.zero_flag)) pc_d = ir_q.operand;
        if (dec_q.is_hlt)  state_d = S_HALT;
        else if (bus.run)  state_d = S_FETCH;
        else               state_d = S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.state = 2'd0;
    case (state_q)
      S_FETCH:   bus.state = 2'd1;
      S_DECODE:  bus.state = 2'd2;
      S_EXECUTE: bus.state = 2'd3;
      default:   bus.state = 2'd0;
    endcase
  end

  assign bus.rom_addr   = pc_q;
  assign bus.ctl_acc_we = dec_q.acc_we;
  assign bus.ctl_alu_op = dec_q.alu_op;
  assign bus.ctl_out_we = dec_q.out_we;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.ctl_imm    = (state_q == S_DECODE || state_q == S_EXECUTE) ? ir_q.operand : '0;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with a behavioural ROM array.
// Cycle n = state visible n rising edges after reset release.
module tb_cpu_control_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] rom [16];
  logic [7:0] rom_word;

  cpu_control_unit_if bif ();

  cpu_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  always #5 clk = ~clk;

  assign rom_word        = rom[bif.rom_addr];
  assign bif.rom_opcode  = rom_word[7:4];
  assign bif.rom_operand = rom_word[3:0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  // Reset for one edge, then release; returns at the start of cycle 0.
  task automatic restart();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bif.run       = 1'b0;
    bif.zero_flag = 1'b0;
    clear_rom();

    // ---------------- reset state ----------------
    tick();
    chk("rst_state", {6'd0, bif.state}, 8'd0);
    chk("rst_addr", {4'd0, bif.rom_addr}, 8'h0);
    chk("rst_halted", {7'd0, bif.halted}, 8'd0);
    chk("rst_strobes", {6'd0, bif.ctl_acc_we, bif.ctl_out_we}, 8'd0);
    chk("rst_imm", {4'd0, bif.ctl_imm}, 8'd0);

    // ---------------- straight-line program ----------------
    rom[0] = 8'h13;  // LDI 3
    rom[1] = 8'h22;  // ADDI 2
    rom[2] = 8'h60;  // OUT
    rom[3] = 8'hF0;  // HLT
    bif.run = 1'b1;
    restart();
    for (int c = 1; c <= 14; c++) begin
      tick();
      chk("sl_acc_we", {7'd0, bif.ctl_acc_we}, {7'd0, (c == 3 || c == 6)});
      chk("sl_out_we", {7'd0, bif.ctl_out_we}, {7'd0, (c == 9)});
      chk("sl_halted", {7'd0, bif.halted}, {7'd0, (c >= 13)});
      if (c == 1) chk("sl_fetch_state", {6'd0, bif.state}, 8'd1);
      if (c == 2) chk("sl_imm_decode", {4'd0, bif.ctl_imm}, 8'd3);
      if (c == 3) begin
        chk("sl_imm_ldi", {4'd0, bif.ctl_imm}, 8'd3);
        chk("sl_alu_ldi", {6'd0, bif.ctl_alu_op}, 8'd0);
        chk("sl_exec_state", {6'd0, bif.state}, 8'd3);
      end
      if (c == 6) begin
        chk("sl_imm_addi", {4'd0, bif.ctl_imm}, 8'd2);
        chk("sl_alu_addi", {6'd0, bif.ctl_alu_op}, 8'd1);
      end
      if (c == 7) chk("sl_imm_idle_fetch", {4'd0, bif.ctl_imm}, 8'd0);
    end
    chk("sl_halt_pc", {4'd0, bif.rom_addr}, 8'h4);
    chk("sl_halt_state", {6'd0, bif.state}, 8'd0);

    // ---------------- HALT stickiness ----------------
    for (int i = 0; i < 6; i++) begin
      bif.run = i[0];
      tick();
      chk("halt_sticky", {7'd0, bif.halted}, 8'd1);
      chk("halt_pc", {4'd0, bif.rom_addr}, 8'h4);
      chk("halt_state", {6'd0, bif.state}, 8'd0);
    end
    rst = 1'b1;
    #1;
    chk("halt_rst_clear", {7'd0, bif.halted}, 8'd0);

    // ---------------- reset mid-instruction ----------------
    clear_rom();
    rom[4] = 8'h17;  // LDI 7 executes in cycle 15 with pc=5
    bif.run = 1'b1;
    restart();
    for (int c = 1; c <= 15; c++) tick();
    chk("mid_acc_we", {7'd0, bif.ctl_acc_we}, 8'd1);
    chk("mid_pc", {4'd0, bif.rom_addr}, 8'h5);
    chk("mid_state", {6'd0, bif.state}, 8'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", {4'd0, bif.rom_addr}, 8'h0);
    chk("arst_state", {6'd0, bif.state}, 8'd0);
    chk("arst_acc_we", {7'd0, bif.ctl_acc_we}, 8'd0);
    chk("arst_imm", {4'd0, bif.ctl_imm}, 8'd0);
    bif.run = 1'b0;
    restart();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_addr", {4'd0, bif.rom_addr}, 8'h0);
      chk("idle_state", {6'd0, bif.state}, 8'd0);
    end

    // ---------------- jumps, zero_flag = 1 ----------------
    clear_rom();
    rom[0]  = 8'h4A;  // JMP 0xA
    rom[10] = 8'h52;  // JZ 0x2
    bif.zero_flag = 1'b1;
    bif.run = 1'b1;
    restart();
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 2) chk("jmp_decode_pc", {4'd0, bif.rom_addr}, 8'h1);
      if (c == 4) begin
        chk("jmp_target", {4'd0, bif.rom_addr}, 8'hA);
        chk("jmp_fetch_state", {6'd0, bif.state}, 8'd1);
      end
      if (c == 5) chk("jz_decode_pc", {4'd0, bif.rom_addr}, 8'hB);
      if (c == 7) chk("jz_taken", {4'd0, bif.rom_addr}, 8'h2);
    end

    // ---------------- jumps, zero_flag = 0 ----------------
    bif.zero_flag = 1'b0;
    restart();
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 4) chk("jmp_target2", {4'd0, bif.rom_addr}, 8'hA);
      if (c == 7) chk("jz_not_taken", {4'd0, bif.rom_addr}, 8'hB);
    end

    // ---------------- PC wrap through NOPs ----------------
    clear_rom();
    restart();
    for (int c = 1; c <= 52; c++) begin
      tick();
      chk("wrap_no_strobe", {6'd0, bif.ctl_acc_we, bif.ctl_out_we}, 8'd0);
      if (c == 43) chk("wrap_e", {4'd0, bif.rom_addr}, 8'hE);
      if (c == 46) chk("wrap_f", {4'd0, bif.rom_addr}, 8'hF);
      if (c == 49) chk("wrap_0", {4'd0, bif.rom_addr}, 8'h0);
      if (c == 52) chk("wrap_1", {4'd0, bif.rom_addr}, 8'h1);
    end

    // ---------------- run gating ----------------
    clear_rom();
    rom[0] = 8'h15;  // LDI 5
    rom[1] = 8'h21;  // ADDI 1
    bif.run = 1'b1;
    restart();
    tick();  // cycle 1 FETCH
    tick();  // cycle 2 DECODE
    chk("gate_decode_state", {6'd0, bif.state}, 8'd2);
    bif.run = 1'b0;
    tick();  // cycle 3 EXECUTE still completes
    chk("gate_acc_we", {7'd0, bif.ctl_acc_we}, 8'd1);
    chk("gate_imm", {4'd0, bif.ctl_imm}, 8'd5);
    tick();  // cycle 4
    chk("gate_idle_state", {6'd0, bif.state}, 8'd0);
    chk("gate_idle_pc", {4'd0, bif.rom_addr}, 8'h1);
    tick();  // cycle 5
    tick();  // cycle 6
    chk("gate_still_idle", {6'd0, bif.state}, 8'd0);
    chk("gate_no_strobe", {7'd0, bif.ctl_acc_we}, 8'd0);
    bif.run = 1'b1;
    tick();  // cycle 7 FETCH of addr 1
    chk("resume_fetch", {6'd0, bif.state}, 8'd1);
    chk("resume_pc", {4'd0, bif.rom_addr}, 8'h1);
    tick();  // cycle 8
    tick();  // cycle 9 EXECUTE ADDI 1
    chk("resume_acc_we", {7'd0, bif.ctl_acc_we}, 8'd1);
    chk("resume_alu", {6'd0, bif.ctl_alu_op}, 8'd1);
    chk("resume_imm", {4'd0, bif.ctl_imm}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
